la_sample_capture: RTL and testbench

Capture engine for the logic analyser, and the consumer of the sample-rate strobe produced by the sample clock divider. On each strobe it writes the probe word into a circular buffer and evaluates a mask/value trigger. It keeps a programmable number of pre-trigger samples and fills the rest of the buffer with post-trigger samples. After capture, the host-side reader fetches samples in chronological order through a 1-cycle-latency read port.

---
 rtl/la_sample_capture.sv | 202 ++++++++++++++++++++
 tb/tb_la_sample_capture.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_sample_capture.sv
// ---------------------------------------------------------------------------
// la_sample_capture
// Logic-analyser capture engine. Each sample_en strobe writes the probe word
// into a circular buffer and, once the pre-trigger window is full, evaluates
// a mask/value trigger. After the trigger the remainder of the buffer is
// filled with post-trigger samples. The finished capture is read back in
// chronological order (index 0 = oldest) through a 1-cycle-latency port.
//
// Handshake: rd_en is a one-cycle request with no backpressure. rd_valid is
// high exactly one cycle after each accepted rd_en, and rd_data holds that
// request's sample in the same cycle. A request every cycle gives one result
// every cycle.
// ---------------------------------------------------------------------------
module la_sample_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] probe_in,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_depth,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [2:0]        state,
    output logic              triggered,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRETRIG   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POSTTRIG  = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Control registers
    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_pre_lat;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_post_left;
    logic [ADDR_W-1:0] r_trig_addr;
    logic              r_triggered;
    logic              r_done;
    logic              r_force_pend;

    // Read port registers
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // Sample buffer: one write port, one registered read port
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Combinational helpers
    logic              w_capturing;
    logic              w_wr_en;
    logic              w_match;
    logic              w_fire;
    logic [ADDR_W-1:0] w_pre_next;
    logic [ADDR_W-1:0] w_post_next;
    logic [ADDR_W-1:0] w_post_init;
    logic [ADDR_W-1:0] w_start_addr;
    logic [ADDR_W-1:0] w_rd_phys;

    assign w_capturing = (r_state == S_PRETRIG) ||
                         (r_state == S_WAIT_TRIG) ||
                         (r_state == S_POSTTRIG);

    // arm and abort both take precedence over a coincident strobe, so that
    // strobe is neither stored nor counted.
    assign w_wr_en     = sample_en && w_capturing && !arm && !abort;

    // A zero mask leaves nothing to compare, so every sample matches.
    assign w_match     = ((probe_in ^ trig_value) & trig_mask) == '0;

    // A force pulse arriving together with a strobe counts straight away.
    assign w_fire      = w_match || r_force_pend || force_trig;

    assign w_pre_next  = r_pre_cnt + 1'b1;
    assign w_post_next = r_post_left - 1'b1;

    // Samples still to take after the trigger sample: DEPTH - 1 - pre_lat.
    assign w_post_init = {ADDR_W{1'b1}} - r_pre_lat;

    // The oldest sample sits pre_lat slots before the trigger sample.
    assign w_start_addr = r_trig_addr - r_pre_lat;
    assign w_rd_phys    = w_start_addr + rd_addr;

    // Capture FSM: arm > abort > strobe-driven progress through the phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_pre_lat    <= '0;
            r_pre_cnt    <= '0;
            r_post_left  <= '0;
            r_trig_addr  <= '0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_force_pend <= 1'b0;
        end else if (arm) begin
            r_pre_lat    <= pre_depth;
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_left  <= '0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_force_pend <= 1'b0;
            r_state      <= (pre_depth == '0) ? S_WAIT_TRIG : S_PRETRIG;
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_force_pend <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case (r_state)
                S_PRETRIG: begin
                    // Fill the pre-trigger window; no trigger evaluation yet.
                    if (sample_en) begin
                        r_pre_cnt <= w_pre_next;
                        if (w_pre_next == r_pre_lat) begin
                            r_state <= S_WAIT_TRIG;
                        end
                    end
                end

                S_WAIT_TRIG: begin
                    if (sample_en && w_fire) begin
                        r_trig_addr  <= r_wr_ptr;
                        r_triggered  <= 1'b1;
                        r_post_left  <= w_post_init;
                        r_force_pend <= 1'b0;
                        if (w_post_init == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_POSTTRIG;
                        end
                    end else if (force_trig) begin
                        r_force_pend <= 1'b1;
                    end
                end

                S_POSTTRIG: begin
                    if (sample_en) begin
                        r_post_left <= w_post_next;
                        if (w_post_next == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    // IDLE and DONE hold until arm or abort.
                end
            endcase
        end
    end

    // Buffer write: store the probe word at the write pointer on each capture strobe
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= probe_in;
        end
    end

    // Read port: translate logical index to buffer slot and register the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_mem[w_rd_phys];
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign state     = r_state;
    assign triggered = r_triggered;
    assign done      = r_done;

endmodule

// File: tb/tb_la_sample_capture.sv
// ---------------------------------------------------------------------------
// tb_la_sample_capture
// Self-checking bench for la_sample_capture with a 16-entry buffer. The
// reference model records every sample accepted since arm in a queue and
// derives phase, trigger position and buffer contents from those counts.
// ---------------------------------------------------------------------------
module tb_la_sample_capture;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_en;
    logic [DATA_W-1:0] probe_in;
    logic              arm;
    logic              abort;
    logic              force_trig;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_value;
    logic [ADDR_W-1:0] pre_depth;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        state;
    logic              triggered;
    logic              done;

    always #5 clk = ~clk;

    la_sample_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .probe_in   (probe_in),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .pre_depth  (pre_depth),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .state      (state),
        .triggered  (triggered),
        .done       (done)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] hist[$];   // samples accepted since arm, oldest first
    int                m_pre;
    int                m_trig;    // index in hist of trigger sample, -1 if none
    bit                m_idle;
    bit                m_done;
    bit                m_force;
    logic [DATA_W-1:0] m_mask;
    logic [DATA_W-1:0] m_val;

    function automatic logic [4:0] exp_status();
        logic [2:0] s;
        if (m_idle)           s = 3'd0;
        else if (m_done)      s = 3'd4;
        else if (m_trig < 0)  s = (hist.size() < m_pre) ? 3'd1 : 3'd2;
        else                  s = 3'd3;
        return {s, (!m_idle && m_trig >= 0), m_done};
    endfunction

    function automatic logic [DATA_W-1:0] exp_at(input int i);
        return hist[hist.size() - DEPTH + i];
    endfunction

    task automatic model_arm(input int p);
        hist.delete();
        m_pre   = p;
        m_trig  = -1;
        m_idle  = 1'b0;
        m_done  = 1'b0;
        m_force = 1'b0;
    endtask

    task automatic model_abort();
        m_idle  = 1'b1;
        m_done  = 1'b0;
        m_trig  = -1;
        m_force = 1'b0;
    endtask

    task automatic model_force();
        if (!m_idle && !m_done && m_trig < 0 && hist.size() >= m_pre)
            m_force = 1'b1;
    endtask

    task automatic model_strobe(input logic [DATA_W-1:0] d);
        int k;
        if (!m_idle && !m_done) begin
            k = hist.size();
            hist.push_back(d);
            if (m_trig < 0 && k >= m_pre &&
                ((((d ^ m_val) & m_mask) == 0) || m_force)) begin
                m_trig  = k;
                m_force = 1'b0;
            end
            if (m_trig >= 0 && (hist.size() - 1 - m_trig) == DEPTH - 1 - m_pre)
                m_done = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: inputs applied at negedge, pulses dropped 1ns after posedge.
    task automatic cycle(input bit en, input logic [DATA_W-1:0] d,
                         input bit a, input bit ab, input bit f);
        @(negedge clk);
        sample_en  = en;
        probe_in   = d;
        arm        = a;
        abort      = ab;
        force_trig = f;
        @(posedge clk);
        #1;
        sample_en  = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        model_strobe(d);
    endtask

    task automatic arm_capture(input int p, input logic [DATA_W-1:0] mask,
                               input logic [DATA_W-1:0] val);
        trig_mask  = mask;
        trig_value = val;
        m_mask     = mask;
        m_val      = val;
        pre_depth  = ADDR_W'(p);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        model_arm(p);
    endtask

    task automatic read_one(input int a);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(a);
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({state, triggered, done, rd_valid} !== 6'b0)
            $display("FAIL reset_status: got %b expected %b",
                     {state, triggered, done, rd_valid}, 6'b0);
        else ;
        if ({state, triggered, done, rd_valid} !== 6'b0) errors++;
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_abort();
        strobe(8'h5A);
        checks++;
        if ({state, triggered, done} !== exp_status()) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b",
                     {state, triggered, done}, exp_status());
        end
    endtask

    // Reads all DEPTH logical indices back to back and checks each result.
    task automatic test_readback(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            read_one(i);
            checks++;
            if ({rd_valid, rd_data} !== {1'b1, exp_at(i)}) begin
                errors++;
                $display("FAIL %s_read[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                         tag, i, rd_valid, rd_data, exp_at(i));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_drop: got %b expected 0", tag, rd_valid);
        end
    endtask

    task automatic test_basic_trigger();
        logic [DATA_W-1:0] d;
        arm_capture(4, 8'h01, 8'h01);
        checks++;
        if ({state, triggered, done} !== exp_status()) begin
            errors++;
            $display("FAIL basic_arm: got %b expected %b", {state, triggered, done}, exp_status());
        end
        for (int k = 1; k <= 23; k++) begin
            d = (k == 10) ? 8'h11 : 8'((k - 1) * 2);
            strobe(d);
            checks++;
            if ({state, triggered, done} !== exp_status()) begin
                errors++;
                $display("FAIL basic_strobe[%0d]: got %b expected %b",
                         k, {state, triggered, done}, exp_status());
            end
            if (k % 3 == 0) cycle(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        end
        test_readback("basic");
    endtask

    task automatic test_pre_zero();
        logic [DATA_W-1:0] d;
        arm_capture(0, 8'h00, 8'h00);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL prezero_arm_state: got %0d expected 2", state);
        end
        for (int k = 1; k <= 16; k++) begin
            d = 8'($urandom);
            strobe(d);
            checks++;
            if ({state, triggered, done} !== exp_status()) begin
                errors++;
                $display("FAIL prezero_strobe[%0d]: got %b expected %b",
                         k, {state, triggered, done}, exp_status());
            end
        end
        read_one(0);
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, hist[0]}) begin
            errors++;
            $display("FAIL prezero_first: got valid=%b data=%h expected valid=1 data=%h",
                     rd_valid, rd_data, hist[0]);
        end
        test_readback("prezero");
    endtask

    task automatic test_force();
        logic [DATA_W-1:0] d;
        arm_capture(4, 8'hFF, 8'hAA);
        for (int k = 1; k <= 20; k++) begin
            d = 8'($urandom);
            if (d == 8'hAA) d = 8'hAB;
            strobe(d);
            checks++;
            if ({state, triggered, done} !== exp_status()) begin
                errors++;
                $display("FAIL force_pre[%0d]: got %b expected %b",
                         k, {state, triggered, done}, exp_status());
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        model_force();
        checks++;
        if ({state, triggered, done} !== exp_status()) begin
            errors++;
            $display("FAIL force_pulse: got %b expected %b", {state, triggered, done}, exp_status());
        end
        for (int k = 1; k <= 12; k++) begin
            d = 8'($urandom);
            if (d == 8'hAA) d = 8'hAB;
            strobe(d);
            checks++;
            if ({state, triggered, done} !== exp_status()) begin
                errors++;
                $display("FAIL force_post[%0d]: got %b expected %b",
                         k, {state, triggered, done}, exp_status());
            end
        end
        test_readback("force");
    endtask

    task automatic test_abort_rearm();
        arm_capture(2, 8'h00, 8'h00);
        for (int k = 1; k <= 6; k++) strobe(8'(8'h30 + k));
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL abort_in_post: got %0d expected 3", state);
        end
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        model_abort();
        checks++;
        if ({state, triggered, done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_status: got %b expected 00000", {state, triggered, done});
        end
        strobe(8'h78);
        checks++;
        if ({state, triggered, done} !== exp_status()) begin
            errors++;
            $display("FAIL abort_idle_strobe: got %b expected %b", {state, triggered, done}, exp_status());
        end
        // Re-arm together with abort and a strobe: arm wins, strobe is dropped.
        trig_mask = 8'h00; trig_value = 8'h00; m_mask = 8'h00; m_val = 8'h00;
        pre_depth = 4'd5;
        cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        model_arm(5);
        checks++;
        if ({state, triggered, done} !== exp_status()) begin
            errors++;
            $display("FAIL rearm_status: got %b expected %b", {state, triggered, done}, exp_status());
        end
        for (int k = 1; k <= 17; k++) begin
            strobe(8'(8'h80 + k));
            checks++;
            if ({state, triggered, done} !== exp_status()) begin
                errors++;
                $display("FAIL rearm_strobe[%0d]: got %b expected %b",
                         k, {state, triggered, done}, exp_status());
            end
        end
        test_readback("rearm");
    endtask

    task automatic test_reset_mid();
        arm_capture(2, 8'hFF, 8'h55);
        for (int k = 1; k <= 5; k++) strobe(8'(8'h10 + k));
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL resetmid_wait: got %0d expected 2", state);
        end
        read_one(3);
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_pre_valid: got %b expected 1", rd_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, triggered, done, rd_valid, rd_data} !== 14'b0) begin
            errors++;
            $display("FAIL resetmid_async: got %b expected all zero",
                     {state, triggered, done, rd_valid, rd_data});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_abort();
        for (int k = 1; k <= 4; k++) begin
            strobe((k == 2) ? 8'h55 : 8'h12);
            checks++;
            if ({state, triggered, done} !== exp_status()) begin
                errors++;
                $display("FAIL resetmid_idle[%0d]: got %b expected %b",
                         k, {state, triggered, done}, exp_status());
            end
        end
    endtask

    task automatic test_read_newest();
        arm_capture(7, 8'h00, 8'h00);
        for (int k = 1; k <= 16; k++) strobe(8'($urandom));
        @(posedge clk);
        #1;
        checks++;
        if ({done, rd_valid} !== 2'b10) begin
            errors++;
            $display("FAIL newest_before: got done,valid=%b expected 10", {done, rd_valid});
        end
        read_one(15);
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, hist[hist.size() - 1]}) begin
            errors++;
            $display("FAIL newest_read: got valid=%b data=%h expected valid=1 data=%h",
                     rd_valid, rd_data, hist[hist.size() - 1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL newest_pulse: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_random();
        int p;
        int n;
        logic [DATA_W-1:0] mk;
        logic [DATA_W-1:0] vl;
        logic [DATA_W-1:0] d;
        for (int it = 0; it < 6; it++) begin
            p  = $urandom_range(0, DEPTH - 1);
            mk = 8'($urandom) & 8'($urandom) & 8'($urandom);
            vl = 8'($urandom);
            arm_capture(p, mk, vl);
            n = 0;
            while (!m_done && n < 300) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 9) == 0 || n > 200) begin
                        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
                        model_force();
                    end else begin
                        cycle(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
                    end
                end
                d = 8'($urandom);
                strobe(d);
                n++;
                checks++;
                if ({state, triggered, done} !== exp_status()) begin
                    errors++;
                    $display("FAIL random[%0d]_strobe[%0d]: got %b expected %b",
                             it, n, {state, triggered, done}, exp_status());
                end
            end
            checks++;
            if (!m_done || done !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d]_complete: got done=%b expected 1 within budget", it, done);
            end
            if (m_done) test_readback("random");
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        sample_en  = 1'b0;
        probe_in   = '0;
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
        trig_mask  = '0;
        trig_value = '0;
        pre_depth  = '0;
        rd_addr    = '0;
        rd_en      = 1'b0;
        m_mask     = '0;
        m_val      = '0;
        model_abort();

        test_reset();
        test_basic_trigger();
        test_pre_zero();
        test_force();
        test_abort_rearm();
        test_reset_mid();
        test_read_newest();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
